// File: rtl/spec_fifo_readout_if.sv
// FIFO read port and packed output lanes of the spectrum readout.
// master = readout block, slave = FIFO / host side.
interface spec_fifo_readout_if #(
  parameter int unsigned ACC_W = 32
);
  logic [ACC_W-1:0] fifo_dout_i;
  logic             fifo_empty_i;
  logic             fifo_rd_en_o;
  logic [15:0]      y0_o;
  logic [15:0]      y0z_o;
  logic [15:0]      y1_o;
  logic [15:0]      y1z_o;
  logic             data_valid_o;

  modport master (
    input  fifo_dout_i, fifo_empty_i,
    output fifo_rd_en_o, y0_o, y0z_o, y1_o, y1z_o, data_valid_o
  );

  modport slave (
    output fifo_dout_i, fifo_empty_i,
    input  fifo_rd_en_o, y0_o, y0z_o, y1_o, y1z_o, data_valid_o
  );
endinterface

// File: rtl/spec_fifo_readout.sv
// Drains one accumulated-spectrum frame from the FIFO and packs it two words per beat behind a header.
// Optional SPEC_FIFO_READOUT_CHECKSUM_EN appends a trailer beat carrying the 32-bit word sum.
module spec_fifo_readout #(
  parameter int unsigned ACC_W = 32,
  parameter logic [15:0] MAGIC = 16'hCCD1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                frame_start_i,
  input  logic [15:0]         n_range_bins_i,
  input  logic [15:0]         spec_lo_i,
  input  logic [15:0]         spec_hi_i,
  spec_fifo_readout_if.master bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);

`ifdef SPEC_FIFO_READOUT_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_READ, S_TRAILER, S_DONE} state_t;
  localparam state_t S_AFTER_DATA = S_TRAILER;
`else
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_READ, S_DONE} state_t;
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t state_q, state_d;

  logic [16:0]      nspec_d;
  logic [31:0]      total_d;
  logic [31:0]      total_q;
  logic [31:0]      req_q;
  logic [31:0]      ret_q;
  logic [ACC_W-1:0] even_q;
  logic             rd_pend_q;
  logic [15:0]      frame_cnt_q;
  logic             last_q;
  logic             rd_en;
  logic             start_ok;
  logic             word_last;
  logic [15:0]      y0_d, y0z_d, y1_d, y1z_d;
  logic             dv_d, last_d;
`ifdef SPEC_FIFO_READOUT_CHECKSUM_EN
  logic [31:0]      sum_q;
`endif

  // 17-bit span so hi=FFFF, lo=0 yields 65536 bins rather than wrapping to 0
  assign nspec_d  = (spec_hi_i >= spec_lo_i) ? ({1'b0, spec_hi_i} - {1'b0, spec_lo_i} + 17'd1) : '0;
  assign total_d  = 32'(n_range_bins_i) * 32'(nspec_d);
  assign start_ok = (state_q == S_IDLE) && frame_start_i;
  assign rd_en    = (state_q == S_READ) && !bus.fifo_empty_i && (req_q < total_q);

  assign bus.fifo_rd_en_o = rd_en;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // last_q marks the final data beat currently on the lanes; leave READ only after it is shown
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (frame_start_i) state_d = S_HEADER;
      S_HEADER:  state_d = (total_q != '0) ? S_READ : S_AFTER_DATA;
      S_READ:    if (last_q) state_d = S_AFTER_DATA;
`ifdef SPEC_FIFO_READOUT_CHECKSUM_EN
      S_TRAILER: state_d = S_DONE;
`endif
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      total_q     <= '0;
      req_q       <= '0;
      ret_q       <= '0;
      even_q      <= '0;
      rd_pend_q   <= 1'b0;
      frame_cnt_q <= '0;
      overrun_o   <= 1'b0;
`ifdef SPEC_FIFO_READOUT_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      rd_pend_q <= rd_en;
      if (start_ok) begin
        total_q     <= total_d;
        req_q       <= '0;
        ret_q       <= '0;
        frame_cnt_q <= frame_cnt_q + 16'd1;
`ifdef SPEC_FIFO_READOUT_CHECKSUM_EN
        sum_q       <= '0;
`endif
      end else begin
        if (rd_en) req_q <= req_q + 32'd1;
        if (rd_pend_q) begin
          ret_q <= ret_q + 32'd1;
          if (!ret_q[0]) even_q <= bus.fifo_dout_i;
`ifdef SPEC_FIFO_READOUT_CHECKSUM_EN
          sum_q <= sum_q + bus.fifo_dout_i;
`endif
        end
      end
      if (frame_start_i && (state_q != S_IDLE)) overrun_o <= 1'b1;
    end
  end

  always_comb begin
    y0_d      = bus.y0_o;
    y0z_d     = bus.y0z_o;
    y1_d      = bus.y1_o;
    y1z_d     = bus.y1z_o;
    dv_d      = 1'b0;
    last_d    = 1'b0;
    word_last = ((ret_q + 32'd1) == total_q);
    if (start_ok) begin
      y0_d  = MAGIC;
      y0z_d = frame_cnt_q;
      y1_d  = n_range_bins_i;
      y1z_d = nspec_d[15:0];
      dv_d  = 1'b1;
    end else if (rd_pend_q) begin
      if (ret_q[0]) begin
        y0_d   = even_q[15:0];
        y0z_d  = even_q[ACC_W-1:16];
        y1_d   = bus.fifo_dout_i[15:0];
        y1z_d  = bus.fifo_dout_i[ACC_W-1:16];
        dv_d   = 1'b1;
        last_d = word_last;
      end else if (word_last) begin
        y0_d   = bus.fifo_dout_i[15:0];
        y0z_d  = bus.fifo_dout_i[ACC_W-1:16];
        y1_d   = '0;
        y1z_d  = '0;
        dv_d   = 1'b1;
        last_d = 1'b1;
      end
    end
`ifdef SPEC_FIFO_READOUT_CHECKSUM_EN
    else if (((state_q == S_READ) && last_q) || ((state_q == S_HEADER) && (total_q == '0))) begin
      y0_d           = ~MAGIC;
      y0z_d          = frame_cnt_q - 16'd1;
      {y1z_d, y1_d}  = sum_q;
      dv_d           = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.y0_o         <= '0;
      bus.y0z_o        <= '0;
      bus.y1_o         <= '0;
      bus.y1z_o        <= '0;
      bus.data_valid_o <= 1'b0;
      last_q           <= 1'b0;
    end else begin
      bus.y0_o         <= y0_d;
      bus.y0z_o        <= y0z_d;
      bus.y1_o         <= y1_d;
      bus.y1z_o        <= y1z_d;
      bus.data_valid_o <= dv_d;
      last_q           <= last_d;
    end
  end

endmodule

// File: tb/tb_spec_fifo_readout.sv
// Directed bench for spec_fifo_readout: table of frame configs plus odd/stall/overrun/reset sequences.
module tb_spec_fifo_readout;
  localparam logic [15:0] MAGIC = 16'hCCD1;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [15:0] nrb_in, lo_in, hi_in;
  logic        busy, done, overrun;

  spec_fifo_readout_if #(.ACC_W(32)) bus_if();

  spec_fifo_readout #(.ACC_W(32), .MAGIC(MAGIC)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .frame_start_i  (frame_start),
    .n_range_bins_i (nrb_in),
    .spec_lo_i      (lo_in),
    .spec_hi_i      (hi_in),
    .bus            (bus_if),
    .busy_o         (busy),
    .done_o         (done),
    .overrun_o      (overrun)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after rd_en
  logic [31:0] mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        flush = 1'b0;
  int          cyc = 0;
  int          stall_lo = 0, stall_hi = 0;

  assign bus_if.fifo_empty_i = (rd_ptr == wr_ptr) || ((cyc >= stall_lo) && (cyc < stall_hi));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) rd_ptr <= wr_ptr;
    else if (bus_if.fifo_rd_en_o && !bus_if.fifo_empty_i) begin
      bus_if.fifo_dout_i <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  logic [63:0] blane [0:511];
  int          bcyc  [0:511];
  int          nb = 0, done_cnt = 0, done_cyc = 0, rd_cnt = 0, bad_rd = 0, rd_stall = 0;

  always @(negedge clk) begin
    if (bus_if.data_valid_o) begin
      if (nb < 512) begin
        blane[nb] <= {bus_if.y0_o, bus_if.y0z_o, bus_if.y1_o, bus_if.y1z_o};
        bcyc[nb]  <= cyc;
      end
      nb <= nb + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus_if.fifo_rd_en_o) rd_cnt <= rd_cnt + 1;
    if (bus_if.fifo_rd_en_o && bus_if.fifo_empty_i) bad_rd <= bad_rd + 1;
    if (bus_if.fifo_rd_en_o && (cyc >= stall_lo) && (cyc < stall_hi)) rd_stall <= rd_stall + 1;
  end

  int n_chk = 0, n_pass = 0;
  logic [15:0] exp_fcnt = 16'd0;
  logic [31:0] fw [0:15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // kind: 0 = plain, 1 = 20-cycle empty gap after the 3rd read, 2 = extra frame_start during READ
  task automatic run_frame(input logic [15:0] nrb, input logic [15:0] lo, input logic [15:0] hi,
                           input logic [15:0] nspec, input int total, input int kind, input int extra);
    int t0, nb0, rd0, dn0, rs0, nexp, ecyc, gap;
    logic [15:0] fc;
    logic [31:0] e, o;
`ifdef SPEC_FIFO_READOUT_CHECKSUM_EN
    logic [31:0] sum;
`endif
    for (int i = 0; i < total + extra; i++) begin
      mem[wr_ptr] = fw[i];
      wr_ptr = wr_ptr + 8'd1;
    end
    nrb_in = nrb; lo_in = lo; hi_in = hi;
    frame_start = 1'b1;
    t0 = cyc; nb0 = nb; rd0 = rd_cnt; dn0 = done_cnt; rs0 = rd_stall;
    fc = exp_fcnt;
    exp_fcnt = exp_fcnt + 16'd1;
    if (kind == 1) begin
      stall_lo = t0 + 5;
      stall_hi = t0 + 25;
    end
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 400 && done_cnt == dn0; k++) begin
      tick();
      frame_start = (kind == 2) && (cyc == t0 + 6);
    end
    frame_start = 1'b0;
    check("done_seen", 64'(done_cnt - dn0), 64'd1);
    nexp = 1 + (total + 1) / 2;
`ifdef SPEC_FIFO_READOUT_CHECKSUM_EN
    nexp++;
`endif
    check("beat_count", 64'(nb - nb0), 64'(nexp));
    if (nb - nb0 == nexp) begin
      check("header", blane[nb0], {MAGIC, fc, nrb, nspec});
      check("header_cyc", 64'(bcyc[nb0]), 64'(t0 + 1));
      for (int b = 0; b < (total + 1) / 2; b++) begin
        e = fw[2*b];
        o = (2*b + 1 < total) ? fw[2*b+1] : 32'd0;
        check("data_beat", blane[nb0+1+b], {e[15:0], e[31:16], o[15:0], o[31:16]});
        if (kind != 1) begin
          ecyc = t0 + 4 + ((2*b + 1 < total) ? 2*b + 1 : total - 1);
          check("beat_cyc", 64'(bcyc[nb0+1+b]), 64'(ecyc));
        end
      end
`ifdef SPEC_FIFO_READOUT_CHECKSUM_EN
      sum = 32'd0;
      for (int i = 0; i < total; i++) sum = sum + fw[i];
      check("trailer", blane[nb0+nexp-1], {~MAGIC, fc, sum[15:0], sum[31:16]});
`endif
      check("done_cyc", 64'(done_cyc), 64'(bcyc[nb0+nexp-1] + 1));
      if (kind == 1) begin
        gap = 0;
        for (int b = nb0; b < nb; b++)
          if (bcyc[b] >= t0 + 6 && bcyc[b] <= t0 + 26) gap++;
        check("stall_no_beat", 64'(gap), 64'd0);
      end
    end
    check("rd_count", 64'(rd_cnt - rd0), 64'(total));
    if (kind == 1) begin
      check("stall_no_rd", 64'(rd_stall - rs0), 64'd0);
      stall_lo = 0;
      stall_hi = 0;
    end
    tick();
    check("busy_after", 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [15:0] nrb, lo, hi, nspec;
    int          total;
  } vec_t;
  vec_t tbl [0:5];

  initial begin
    tbl[0] = '{nrb: 16'd2, lo: 16'd0,  hi: 16'd3,  nspec: 16'd4, total: 8};
    tbl[1] = '{nrb: 16'd3, lo: 16'd5,  hi: 16'd5,  nspec: 16'd1, total: 3};
    tbl[2] = '{nrb: 16'd1, lo: 16'd7,  hi: 16'd2,  nspec: 16'd0, total: 0};
    tbl[3] = '{nrb: 16'd5, lo: 16'd10, hi: 16'd10, nspec: 16'd1, total: 5};
    tbl[4] = '{nrb: 16'd0, lo: 16'd0,  hi: 16'd3,  nspec: 16'd4, total: 0};
    tbl[5] = '{nrb: 16'd1, lo: 16'd0,  hi: 16'd0,  nspec: 16'd1, total: 1};

    rst = 1'b1; frame_start = 1'b0; nrb_in = '0; lo_in = '0; hi_in = '0;
    repeat (3) tick();
    check("rst_lanes", {bus_if.y0_o, bus_if.y0z_o, bus_if.y1_o, bus_if.y1z_o}, 64'd0);
    check("rst_ctrl", 64'({bus_if.data_valid_o, bus_if.fifo_rd_en_o, busy, done, overrun}), 64'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) fw[i] = 32'(v) * 32'h0001_1000 + 32'(i + 1);
      run_frame(tbl[v].nrb, tbl[v].lo, tbl[v].hi, tbl[v].nspec, tbl[v].total, 0, 0);
      tick();
    end

    // odd total with one surplus word that must stay in the FIFO
    fw[0] = 32'hAAAA5555; fw[1] = 32'h12345678; fw[2] = 32'hDEADBEEF; fw[3] = 32'h0BADF00D;
    run_frame(16'd3, 16'd5, 16'd5, 16'd1, 3, 0, 1);
    check("fifo_left", 64'(wr_ptr - rd_ptr), 64'd1);
    flush = 1'b1; tick(); flush = 1'b0; tick();

    for (int i = 0; i < 16; i++) fw[i] = 32'(i + 1);
    run_frame(16'd2, 16'd0, 16'd3, 16'd4, 8, 1, 0);
    tick();

    check("overrun_pre", 64'(overrun), 64'd0);
    run_frame(16'd2, 16'd0, 16'd3, 16'd4, 8, 2, 0);
    check("overrun_set", 64'(overrun), 64'd1);
    tick();

    // reset in the middle of READ
    for (int i = 0; i < 8; i++) begin
      mem[wr_ptr] = fw[i];
      wr_ptr = wr_ptr + 8'd1;
    end
    nrb_in = 16'd2; lo_in = 16'd0; hi_in = 16'd3; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();
    check("busy_mid", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_lanes", {bus_if.y0_o, bus_if.y0z_o, bus_if.y1_o, bus_if.y1z_o}, 64'd0);
    check("rst_mid_ctrl", 64'({bus_if.data_valid_o, bus_if.fifo_rd_en_o, busy, done, overrun}), 64'd0);
    rst = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0; tick();
    exp_fcnt = 16'd0;
    run_frame(16'd2, 16'd0, 16'd3, 16'd4, 8, 0, 0);

    check("rd_while_empty", 64'(bad_rd), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
